// File: rtl/sdio_reg_bridge.sv
// Frame-driven initiator for the SD-domain 8-bit register bus.
// Decodes header/address/data bytes from rx into register writes or reads, and returns read bytes on tx.
module sdio_reg_bridge #(
  parameter bit              AUTO_INC = 1'b1,
  parameter int unsigned     TO_W     = 16,
  parameter logic [TO_W-1:0] TO_CYC   = TO_W'(16'hFFFF)
) (
  input  logic       sd_clk,
  input  logic       rstn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       abort,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_data_wr_sd,
  output logic       reg_addr_wr_sd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RD_REQ, RD_CAP, RD_WAIT} state_t;

  localparam logic [TO_W-1:0] TO_LAST   = TO_CYC - TO_W'(1);
  localparam bit              TO_EN     = (TO_CYC != '0);
  localparam logic [7:0]      ADDR_STEP = {7'd0, AUTO_INC};

  state_t          state_q;
  logic            dir_q;
  logic [7:0]      len_q;
  logic [7:0]      addr_q;
  logic [7:0]      reg_addr_q;
  logic [7:0]      reg_wdata_q;
  logic [7:0]      tx_data_q;
  logic [TO_W-1:0] to_q;
  logic            wr_stb_q;
  logic            rd_stb_q;
  logic            tx_valid_q;
  logic            done_q;
  logic            err_q;

  logic [7:0]      addr_d;
  logic            to_hit_d;
  logic            rx_open_d;

  assign addr_d    = addr_q + ADDR_STEP;
  assign to_hit_d  = TO_EN && !rx_valid && (to_q == TO_LAST);
  assign rx_open_d = (state_q == ADDR) || (state_q == WDATA);

  // An abort mid-frame refuses the byte so it is not silently swallowed.
  assign rx_ready       = (state_q == IDLE) || (rx_open_d && !abort);
  assign busy           = (state_q != IDLE);
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign reg_addr       = reg_addr_q;
  assign reg_wdata      = reg_wdata_q;
  assign reg_data_wr_sd = wr_stb_q;
  assign reg_addr_wr_sd = rd_stb_q;
  assign frame_done     = done_q;
  assign err_timeout    = err_q;

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      len_q       <= 8'd0;
      addr_q      <= 8'd0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      tx_data_q   <= 8'd0;
      to_q        <= '0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q    <= IDLE;
        tx_valid_q <= 1'b0;
        to_q       <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            to_q <= '0;
            if (rx_valid) begin
              dir_q   <= rx_data[7];
              len_q   <= {1'b0, rx_data[6:0]} + 8'd1;
              state_q <= ADDR;
            end
          end
          // The read strobe is raised on entry to RD_REQ so reg_rdata is valid during RD_CAP.
          ADDR: begin
            if (rx_valid) begin
              addr_q <= rx_data;
              to_q   <= '0;
              if (dir_q) begin
                state_q <= WDATA;
              end else begin
                reg_addr_q <= rx_data;
                rd_stb_q   <= 1'b1;
                state_q    <= RD_REQ;
              end
            end else if (to_hit_d) begin
              to_q    <= '0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              to_q <= to_q + TO_W'(1);
            end
          end
          WDATA: begin
            if (rx_valid) begin
              reg_addr_q  <= addr_q;
              reg_wdata_q <= rx_data;
              wr_stb_q    <= 1'b1;
              addr_q      <= addr_d;
              len_q       <= len_q - 8'd1;
              to_q        <= '0;
              if (len_q == 8'd1) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else if (to_hit_d) begin
              to_q    <= '0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              to_q <= to_q + TO_W'(1);
            end
          end
          RD_REQ: state_q <= RD_CAP;
          RD_CAP: begin
            tx_data_q  <= reg_rdata;
            tx_valid_q <= 1'b1;
            state_q    <= RD_WAIT;
          end
          RD_WAIT: begin
            if (tx_ready) begin
              tx_valid_q <= 1'b0;
              addr_q     <= addr_d;
              len_q      <= len_q - 8'd1;
              if (len_q == 8'd1) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                reg_addr_q <= addr_d;
                rd_stb_q   <= 1'b1;
                state_q    <= RD_REQ;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdio_reg_bridge.sv
// Self-checking bench for sdio_reg_bridge: directed vector table, multi-cycle corner sequences
// and randomized frames checked against a transaction-level register-file model.
module tb_sdio_reg_bridge;

  typedef struct packed {
    logic [7:0]      hdr;
    logic [7:0]      addr;
    logic [3:0][7:0] dat;
    logic [2:0]      nExp;
    logic [3:0][7:0] expAddr;
    logic [3:0][7:0] expData;
    logic            fixCheck;
  } vec_t;

  logic       sdClk;
  logic       rstn;
  logic       rxValid;
  logic [7:0] rxData;
  logic       txReady;
  logic       abortIn;
  logic [7:0] rdata;

  logic       rxReady, txValid, busy, frameDone, errTimeout, wrStb, rdStb;
  logic [7:0] txData, regAddr, regWdata;
  logic       fixRxReady, fixTxValid, fixBusy, fixDone, fixErr, fixWrStb, fixRdStb;
  logic [7:0] fixTxData, fixAddr, fixWdata;

  int         assertCount = 0;
  int         failCount   = 0;
  int         txMode      = 0;
  int         doneCnt     = 0;
  int         errCnt      = 0;
  int         bothCnt     = 0;
  int         syncErr     = 0;

  logic [7:0] envMem [256];
  logic [7:0] refMem [256];
  logic [7:0] payload [$];
  logic [7:0] wrAddrQ [$];
  logic [7:0] wrDataQ [$];
  bit         wrDoneQ [$];
  logic [7:0] rdAddrQ [$];
  logic [7:0] txQ [$];
  logic [7:0] fixAddrQ [$];
  logic [7:0] fixDataQ [$];
  logic [7:0] expWrA [$];
  logic [7:0] expWrD [$];
  logic [7:0] expRdA [$];
  logic [7:0] expTx [$];

  sdio_reg_bridge #(.AUTO_INC(1'b1), .TO_W(16), .TO_CYC(16'd8)) dut (
    .sd_clk(sdClk), .rstn(rstn), .rx_valid(rxValid), .rx_data(rxData), .rx_ready(rxReady),
    .tx_valid(txValid), .tx_data(txData), .tx_ready(txReady), .abort(abortIn),
    .reg_addr(regAddr), .reg_wdata(regWdata), .reg_data_wr_sd(wrStb), .reg_addr_wr_sd(rdStb),
    .reg_rdata(rdata), .busy(busy), .frame_done(frameDone), .err_timeout(errTimeout)
  );

  sdio_reg_bridge #(.AUTO_INC(1'b0), .TO_W(16), .TO_CYC(16'd8)) dutFix (
    .sd_clk(sdClk), .rstn(rstn), .rx_valid(rxValid), .rx_data(rxData), .rx_ready(fixRxReady),
    .tx_valid(fixTxValid), .tx_data(fixTxData), .tx_ready(txReady), .abort(abortIn),
    .reg_addr(fixAddr), .reg_wdata(fixWdata), .reg_data_wr_sd(fixWrStb), .reg_addr_wr_sd(fixRdStb),
    .reg_rdata(rdata), .busy(fixBusy), .frame_done(fixDone), .err_timeout(fixErr)
  );

  initial begin
    sdClk = 1'b0;
    forever #5 sdClk = ~sdClk;
  end

  // Register file seen by the bridge: write on strobe, registered read data.
  always @(posedge sdClk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) envMem[i] <= 8'(i) ^ 8'h5A;
      rdata <= 8'h00;
    end else begin
      if (wrStb) envMem[regAddr] <= regWdata;
      if (rdStb) rdata <= envMem[regAddr];
    end
  end

  always @(negedge sdClk) begin
    if (rstn) begin
      if (wrStb) begin
        wrAddrQ.push_back(regAddr);
        wrDataQ.push_back(regWdata);
        wrDoneQ.push_back(frameDone);
      end
      if (rdStb) rdAddrQ.push_back(regAddr);
      if (wrStb && rdStb) bothCnt++;
      if (txValid && txReady) txQ.push_back(txData);
      if (frameDone) doneCnt++;
      if (errTimeout) errCnt++;
      if (fixWrStb) begin
        fixAddrQ.push_back(fixAddr);
        fixDataQ.push_back(fixWdata);
      end
      if ({fixRxReady, fixTxValid, fixBusy, fixDone, fixErr, fixWrStb, fixRdStb, fixTxData} !==
          {rxReady, txValid, busy, frameDone, errTimeout, wrStb, rdStb, txData}) syncErr++;
    end
  end

  initial begin
    txReady = 1'b0;
    forever begin
      @(posedge sdClk);
      #1;
      case (txMode)
        0:       txReady = 1'b1;
        1:       txReady = 1'($urandom_range(1, 0));
        default: txReady = 1'b0;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleCycle();
    @(posedge sdClk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    rxValid = 1'b1;
    rxData  = b;
    while (!hs && n < 50) begin
      @(negedge sdClk);
      hs = rxReady;
      @(posedge sdClk);
      #1;
      n++;
    end
    rxValid = 1'b0;
    if (!hs) checkOutput("rxHandshakeBudget", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] addr, input int gapMax);
    repeat ($urandom_range(gapMax, 0)) idleCycle();
    sendByte(hdr);
    repeat ($urandom_range(gapMax, 0)) idleCycle();
    sendByte(addr);
    if (hdr[7]) begin
      foreach (payload[i]) begin
        repeat ($urandom_range(gapMax, 0)) idleCycle();
        sendByte(payload[i]);
      end
    end
  endtask

  task automatic waitFrame(input string tag);
    int n;
    n = 0;
    @(negedge sdClk);
    while (busy && n < 1000) begin
      @(negedge sdClk);
      n++;
    end
    checkOutput({tag, "_frameEnds"}, 32'(busy), 32'd0);
    @(negedge sdClk);
    @(posedge sdClk);
    #1;
  endtask

  task automatic clearQueues();
    wrAddrQ.delete(); wrDataQ.delete(); wrDoneQ.delete();
    rdAddrQ.delete(); txQ.delete(); fixAddrQ.delete(); fixDataQ.delete();
    doneCnt = 0;
    errCnt  = 0;
  endtask

  // Transaction-level reference: byte i of a frame targets start+i modulo 256.
  task automatic modelFrame(input logic [7:0] hdr, input logic [7:0] start);
    int len;
    logic [7:0] a;
    expWrA.delete(); expWrD.delete(); expRdA.delete(); expTx.delete();
    len = int'(hdr[6:0]) + 1;
    for (int i = 0; i < len; i++) begin
      a = 8'((int'(start) + i) % 256);
      if (hdr[7]) begin
        refMem[a] = payload[i];
        expWrA.push_back(a);
        expWrD.push_back(payload[i]);
      end else begin
        expRdA.push_back(a);
        expTx.push_back(refMem[a]);
      end
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "_writeCount"}, 32'(wrAddrQ.size()), 32'(expWrA.size()));
    checkOutput({tag, "_readCount"}, 32'(rdAddrQ.size()), 32'(expRdA.size()));
    checkOutput({tag, "_txCount"}, 32'(txQ.size()), 32'(expTx.size()));
    for (int i = 0; i < expWrA.size(); i++) begin
      checkOutput({tag, "_writeAddr"}, (i < wrAddrQ.size()) ? 32'(wrAddrQ[i]) : 32'hDEAD, 32'(expWrA[i]));
      checkOutput({tag, "_writeData"}, (i < wrDataQ.size()) ? 32'(wrDataQ[i]) : 32'hDEAD, 32'(expWrD[i]));
    end
    for (int i = 0; i < expRdA.size(); i++) begin
      checkOutput({tag, "_readAddr"}, (i < rdAddrQ.size()) ? 32'(rdAddrQ[i]) : 32'hDEAD, 32'(expRdA[i]));
      checkOutput({tag, "_txByte"}, (i < txQ.size()) ? 32'(txQ[i]) : 32'hDEAD, 32'(expTx[i]));
    end
    checkOutput({tag, "_frameDone"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, "_noTimeout"}, 32'(errCnt), 32'd0);
  endtask

  initial begin
    vec_t vecs [7];
    int   nExp;
    int   k;
    bit   seen;
    logic [7:0] hdr;
    logic [7:0] start;

    vecs[0] = '{hdr:8'h80, addr:8'h1D, dat:32'h00000004, nExp:3'd1, expAddr:32'h0000001D, expData:32'h00000004, fixCheck:1'b0};
    vecs[1] = '{hdr:8'h83, addr:8'h04, dat:32'h44332211, nExp:3'd4, expAddr:32'h07060504, expData:32'h44332211, fixCheck:1'b1};
    vecs[2] = '{hdr:8'h81, addr:8'hFF, dat:32'h00000201, nExp:3'd2, expAddr:32'h000000FF, expData:32'h00000201, fixCheck:1'b0};
    vecs[3] = '{hdr:8'h81, addr:8'h1C, dat:32'h00005AA5, nExp:3'd2, expAddr:32'h00001D1C, expData:32'h00005AA5, fixCheck:1'b0};
    vecs[4] = '{hdr:8'h01, addr:8'h1C, dat:32'h0,        nExp:3'd2, expAddr:32'h00001D1C, expData:32'h00005AA5, fixCheck:1'b0};
    vecs[5] = '{hdr:8'h00, addr:8'h1D, dat:32'h0,        nExp:3'd1, expAddr:32'h0000001D, expData:32'h0000005A, fixCheck:1'b0};
    vecs[6] = '{hdr:8'h01, addr:8'hFF, dat:32'h0,        nExp:3'd2, expAddr:32'h000000FF, expData:32'h00000201, fixCheck:1'b0};

    for (int i = 0; i < 256; i++) refMem[i] = 8'(i) ^ 8'h5A;
    rstn = 1'b0; rxValid = 1'b0; rxData = 8'h00; abortIn = 1'b0; txMode = 0;
    repeat (3) @(posedge sdClk);
    #1 rstn = 1'b1;

    @(negedge sdClk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rxReady", 32'(rxReady), 32'd1);
    checkOutput("reset_txValid", 32'(txValid), 32'd0);
    checkOutput("reset_txData", 32'(txData), 32'd0);
    checkOutput("reset_regAddr", 32'(regAddr), 32'd0);
    checkOutput("reset_regWdata", 32'(regWdata), 32'd0);
    checkOutput("reset_strobes", {30'd0, wrStb, rdStb}, 32'd0);
    checkOutput("reset_pulses", {30'd0, frameDone, errTimeout}, 32'd0);
    @(posedge sdClk);
    #1;

    for (int v = 0; v < 7; v++) begin
      clearQueues();
      nExp = int'(vecs[v].nExp);
      payload.delete();
      if (vecs[v].hdr[7]) for (int i = 0; i <= int'(vecs[v].hdr[6:0]); i++) payload.push_back(vecs[v].dat[i]);
      modelFrame(vecs[v].hdr, vecs[v].addr);
      applyStimulus(vecs[v].hdr, vecs[v].addr, 0);
      waitFrame($sformatf("vec%0d", v));
      if (vecs[v].hdr[7]) begin
        checkOutput($sformatf("vec%0d_writeCount", v), 32'(wrAddrQ.size()), 32'(nExp));
        checkOutput($sformatf("vec%0d_noReadStrobe", v), 32'(rdAddrQ.size()), 32'd0);
        for (int i = 0; i < nExp; i++) begin
          checkOutput($sformatf("vec%0d_writeAddr%0d", v, i), (i < wrAddrQ.size()) ? 32'(wrAddrQ[i]) : 32'hDEAD, 32'(vecs[v].expAddr[i]));
          checkOutput($sformatf("vec%0d_writeData%0d", v, i), (i < wrDataQ.size()) ? 32'(wrDataQ[i]) : 32'hDEAD, 32'(vecs[v].expData[i]));
          checkOutput($sformatf("vec%0d_doneWithStrobe%0d", v, i), (i < wrDoneQ.size()) ? 32'(wrDoneQ[i]) : 32'hDEAD, (i == nExp - 1) ? 32'd1 : 32'd0);
        end
      end else begin
        checkOutput($sformatf("vec%0d_readCount", v), 32'(rdAddrQ.size()), 32'(nExp));
        checkOutput($sformatf("vec%0d_noWriteStrobe", v), 32'(wrAddrQ.size()), 32'd0);
        for (int i = 0; i < nExp; i++) begin
          checkOutput($sformatf("vec%0d_readAddr%0d", v, i), (i < rdAddrQ.size()) ? 32'(rdAddrQ[i]) : 32'hDEAD, 32'(vecs[v].expAddr[i]));
          checkOutput($sformatf("vec%0d_txByte%0d", v, i), (i < txQ.size()) ? 32'(txQ[i]) : 32'hDEAD, 32'(vecs[v].expData[i]));
        end
      end
      checkOutput($sformatf("vec%0d_frameDone", v), 32'(doneCnt), 32'd1);
      if (vecs[v].fixCheck) begin
        checkOutput($sformatf("vec%0d_fixedWriteCount", v), 32'(fixAddrQ.size()), 32'(nExp));
        for (int i = 0; i < nExp; i++) begin
          checkOutput($sformatf("vec%0d_fixedAddr%0d", v, i), (i < fixAddrQ.size()) ? 32'(fixAddrQ[i]) : 32'hDEAD, 32'(vecs[v].addr));
          checkOutput($sformatf("vec%0d_fixedData%0d", v, i), (i < fixDataQ.size()) ? 32'(fixDataQ[i]) : 32'hDEAD, 32'(vecs[v].expData[i]));
        end
      end
    end

    // Read with the front end stalled: tx byte must hold and no next read may start.
    clearQueues();
    txMode = 2;
    sendByte(8'h01);
    sendByte(8'h1C);
    k = 0;
    @(negedge sdClk);
    while (!txValid && k < 20) begin
      @(negedge sdClk);
      k++;
    end
    checkOutput("stall_txValidRises", 32'(txValid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall_txDataHeld%0d", c), {23'd0, txValid, txData}, {23'd0, 1'b1, 8'hA5});
      @(negedge sdClk);
    end
    checkOutput("stall_singleReadStrobe", 32'(rdAddrQ.size()), 32'd1);
    @(posedge sdClk);
    #1;
    txMode = 0;
    waitFrame("stall");
    checkOutput("stall_txCount", 32'(txQ.size()), 32'd2);
    checkOutput("stall_txSecond", (txQ.size() > 1) ? 32'(txQ[1]) : 32'hDEAD, 32'h5A);
    checkOutput("stall_readAddrSecond", (rdAddrQ.size() > 1) ? 32'(rdAddrQ[1]) : 32'hDEAD, 32'h1D);

    // Rx stall after the address byte, then after the header only: 8 idle cycles, then the pulse.
    for (int t = 0; t < 2; t++) begin
      clearQueues();
      sendByte(8'h81);
      if (t == 0) sendByte(8'h30);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 30) begin
        @(negedge sdClk);
        k++;
        if (errTimeout) seen = 1'b1;
      end
      checkOutput($sformatf("timeout%0d_latency", t), 32'(k), 32'd9);
      @(negedge sdClk);
      checkOutput($sformatf("timeout%0d_idle", t), 32'(busy), 32'd0);
      checkOutput($sformatf("timeout%0d_pulseOnce", t), 32'(errCnt), 32'd1);
      checkOutput($sformatf("timeout%0d_noStrobe", t), 32'(wrAddrQ.size() + rdAddrQ.size()), 32'd0);
      checkOutput($sformatf("timeout%0d_noDone", t), 32'(doneCnt), 32'd0);
      @(posedge sdClk);
      #1;
      clearQueues();
      payload.delete();
      payload.push_back(8'h99);
      modelFrame(8'h80, 8'h31);
      applyStimulus(8'h80, 8'h31, 0);
      waitFrame("afterTimeout");
      checkAgainstModel($sformatf("afterTimeout%0d", t));
    end

    // Abort while a read byte waits on tx_ready.
    clearQueues();
    txMode = 2;
    sendByte(8'h01);
    sendByte(8'h40);
    k = 0;
    @(negedge sdClk);
    while (!txValid && k < 20) begin
      @(negedge sdClk);
      k++;
    end
    checkOutput("abort_txValidBefore", 32'(txValid), 32'd1);
    @(posedge sdClk);
    #1 abortIn = 1'b1;
    @(posedge sdClk);
    #1 abortIn = 1'b0;
    @(negedge sdClk);
    checkOutput("abort_txValidDrops", 32'(txValid), 32'd0);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge sdClk);
    checkOutput("abort_noFrameDone", 32'(doneCnt), 32'd0);
    checkOutput("abort_noExtraRead", 32'(rdAddrQ.size()), 32'd1);
    checkOutput("abort_noTxHandshake", 32'(txQ.size()), 32'd0);
    @(posedge sdClk);
    #1;
    txMode = 0;
    clearQueues();
    payload.delete();
    payload.push_back(8'h77);
    modelFrame(8'h80, 8'h41);
    applyStimulus(8'h80, 8'h41, 0);
    waitFrame("afterAbort");
    checkAgainstModel("afterAbort");

    // Randomized frames with rx gaps and tx backpressure.
    txMode = 1;
    for (int f = 0; f < 30; f++) begin
      clearQueues();
      payload.delete();
      hdr   = {1'($urandom_range(1, 0)), 7'($urandom_range(5, 0))};
      start = 8'($urandom);
      if (f % 5 == 0) start = 8'hFE;
      if (hdr[7]) for (int i = 0; i <= int'(hdr[6:0]); i++) payload.push_back(8'($urandom));
      modelFrame(hdr, start);
      applyStimulus(hdr, start, 3);
      waitFrame($sformatf("rand%0d", f));
      checkAgainstModel($sformatf("rand%0d", f));
    end

    checkOutput("strobesNeverTogether", 32'(bothCnt), 32'd0);
    checkOutput("fixedAddrVariantLockstep", 32'(syncErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
